prv32_alu_arbiter: RTL

PRV32_ALU_ARBITER -- requirements
Module: prv32_alu_arbiter

---
 rtl/prv32_alu_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/prv32_alu_arbiter.sv
// ---------------------------------------------------------------------------
// prv32_alu_arbiter
//
// Shares one combinational ALU between two requesters. A grant in IDLE
// registers the winning port's operands onto the alu_* bus. The ALU result is
// captured one cycle later. The response is then held until the consumer
// takes it.
//
// Parameters
//   ROUND_ROBIN  1: alternate between ports when both are valid.
//                0: fixed priority to port 0.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid / reqN_ready          request handshake, port N in {0,1}
//   reqN_a, reqN_b                   32-bit operands
//   reqN_shamt, reqN_alufn           shift amount, ALU function (passed as-is)
//   alu_a, alu_b, alu_shamt,
//   alu_alufn                        registered operands to the shared ALU
//   alu_r, alu_cf/zf/vf/sf           combinational ALU result and flags
//   rsp_valid / rsp_ready            response handshake
//   rsp_id                           port that issued the held response
//   rsp_r, rsp_flags                 registered result, flags {cf,zf,vf,sf}
//   busy                             high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module prv32_alu_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic [3:0]  req0_alufn,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    input  logic [3:0]  req1_alufn,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_alufn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_vf,
    input  logic        alu_sf,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_r,
    output logic [3:0]  rsp_flags,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant;   // port granted on the most recent accept edge
    logic   grant;        // port that would win in IDLE this cycle
    logic   grant_valid;  // the winning port actually has a request
    logic   accept;       // handshake completes on the coming edge

    // -----------------------------------------------------------------------
    // Grant selection. Port 1 wins only when it is the sole requester, or,
    // in round-robin mode, when both request and port 0 was served last.
    // -----------------------------------------------------------------------
    always_comb begin
        if (ROUND_ROBIN) begin
            if (req0_valid && req1_valid) grant = ~last_grant;
            else                          grant = req1_valid;
        end else begin
            grant = ~req0_valid;
        end
        grant_valid = grant ? req1_valid : req0_valid;
    end

    assign accept = (state == IDLE) && grant_valid;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // -----------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand, response and arbitration registers.
    // alu_* keep the last accepted operation. rsp_id doubles as the id
    // register: it is loaded at accept and stays frozen through RESP.
    // -----------------------------------------------------------------------
    // NOTE: all registers here are plain flops, not memories, so each one
    // gets an explicit reset value. last_grant resets to 1 so that port 0
    // wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shamt  <= '0;
            alu_alufn  <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_r      <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a     : req0_a;
                alu_b      <= grant ? req1_b     : req0_b;
                alu_shamt  <= grant ? req1_shamt : req0_shamt;
                alu_alufn  <= grant ? req1_alufn : req0_alufn;
                rsp_id     <= grant;
                last_grant <= grant;
            end

            if (state == EXEC) begin
                rsp_r     <= alu_r;
                rsp_flags <= {alu_cf, alu_zf, alu_vf, alu_sf};
                rsp_valid <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
